// File: rtl/sdram_port_arbiter.sv
// Three-master front end for the SDRAM controller's single req/ack port: round-robin with optional port-0 priority.
// m_req sampled at edge N gives s_req after edge N; losers keep m_req pending (no m_ack) until they are granted.
module sdram_port_arbiter #(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int P0_PRIORITY    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [3*ADDRESS_WIDTH-1:0] m_address,
  input  logic [95:0]                m_data_in,
  input  logic [11:0]                m_nwr,
  input  logic [2:0]                 m_req,
  output logic [2:0]                 m_ack,
  output logic [31:0]                m_rdata,
  output logic [ADDRESS_WIDTH-1:0]   s_address,
  output logic [31:0]                s_data_out,
  output logic [3:0]                 s_nwr,
  output logic                       s_req,
  input  logic                       s_ack,
  input  logic [31:0]                s_data_in,
  output logic [1:0]                 grant,
  output logic                       busy,
  output logic                       err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t                     state_q, state_d;
  logic                       s_req_q, s_req_d;
  logic [2:0]                 m_ack_q, m_ack_d;
  logic [31:0]                m_rdata_q, m_rdata_d;
  logic [ADDRESS_WIDTH-1:0]   s_address_q, s_address_d;
  logic [31:0]                s_data_q, s_data_d;
  logic [3:0]                 s_nwr_q, s_nwr_d;
  logic [1:0]                 grant_q, grant_d;
  logic [1:0]                 last_q, last_d;
  logic                       err_q, err_d;
  logic [15:0]                cnt_q, cnt_d;

  logic [2:0]                 elig;
  logic                       found;
  logic [1:0]                 win;
  logic [1:0]                 cand;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A port whose m_ack is still high has already been served and must drop m_req first.
  always_comb begin
    elig  = m_req & ~m_ack_q;
    found = 1'b0;
    win   = 2'd0;
    cand  = next_port(last_q);
    if (P0_PRIORITY != 0 && elig[0]) begin
      found = 1'b1;
      win   = 2'd0;
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (!found && elig[cand]) begin
          found = 1'b1;
          win   = cand;
        end
        cand = next_port(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    s_req_d     = s_req_q;
    m_ack_d     = m_ack_q;
    m_rdata_d   = m_rdata_q;
    s_address_d = s_address_q;
    s_data_d    = s_data_q;
    s_nwr_d     = s_nwr_q;
    grant_d     = grant_q;
    last_d      = last_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          s_address_d = m_address[int'(win)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          s_data_d    = m_data_in[int'(win)*32 +: 32];
          s_nwr_d     = m_nwr[int'(win)*4 +: 4];
          grant_d     = win;
          s_req_d     = 1'b1;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (s_ack) begin
          // Writes leave the previous read data visible.
          if (s_nwr_q == 4'hF) m_rdata_d = s_data_in;
          m_ack_d[grant_q] = 1'b1;
          s_req_d          = 1'b0;
          state_d          = RELEASE;
        end else if (cnt_q != TMO) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == TMO) err_d = 1'b1;
        end
      end
      RELEASE: begin
        if (!s_ack && !m_req[grant_q]) begin
          m_ack_d = '0;
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= IDLE;
      s_req_q     <= 1'b0;
      m_ack_q     <= '0;
      m_rdata_q   <= '0;
      s_address_q <= '0;
      s_data_q    <= '0;
      s_nwr_q     <= 4'hF;
      grant_q     <= 2'd0;
      last_q      <= 2'd2;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      s_req_q     <= s_req_d;
      m_ack_q     <= m_ack_d;
      m_rdata_q   <= m_rdata_d;
      s_address_q <= s_address_d;
      s_data_q    <= s_data_d;
      s_nwr_q     <= s_nwr_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign m_ack       = m_ack_q;
  assign m_rdata     = m_rdata_q;
  assign s_address   = s_address_q;
  assign s_data_out  = s_data_q;
  assign s_nwr       = s_nwr_q;
  assign s_req       = s_req_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares the single 32-bit request/acknowledge port of the SDRAM controller among three masters: port 0 (video/DMA), port 1 (CPU instruction fetch) and port 2 (CPU data). It sits between the masters and the controller. It is a registered arbiter with round-robin fairness and an optional fixed priority for port 0. A watchdog flags a controller that never acknowledges. Every port uses the same four-phase req/ack handshake as the controller.

Parameters:
ADDRESS_WIDTH, 24, word address width (bank bits + row bits + column bits + chip select bit, matches controller cpu_address)
P0_PRIORITY, 1, 1 = port 0 wins any arbitration it takes part in; 0 = pure round-robin
TIMEOUT_CYCLES, 255, cycles in REQ without s_ack before err_timeout sets; range 1..65535

Ports:
clk  input  1  clock
nreset  input  1  synchronous active-low reset
m_address  input  3*ADDRESS_WIDTH  per-port word address; port i occupies slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
m_data_in  input  96  per-port write data, 32 bits per port
m_nwr  input  12  per-port active-low byte write enables, 4 bits per port; 4'b1111 = read
m_req  input  3  per-port request
m_ack  output  3  per-port acknowledge
m_rdata  output  32  read data, shared by all ports; valid while the owning port's m_ack is high
s_address  output  ADDRESS_WIDTH  to controller cpu_address
s_data_out  output  32  to controller cpu_data_in
s_nwr  output  4  to controller cpu_nwr
s_req  output  1  to controller cpu_req
s_ack  input  1  from controller cpu_ack
s_data_in  input  32  from controller cpu_data_out
grant  output  2  index of the port owning the current transaction (registered)
busy  output  1  high in any state other than IDLE
err_timeout  output  1  sticky watchdog flag

Behaviour:
Reset values (nreset low at a clk edge):
- s_req=0, m_ack=3'b000, m_rdata=0
- s_address=0, s_data_out=0, s_nwr=4'hF
- grant=0, last=2 (so port 0 is first in round-robin), err_timeout=0, state=IDLE
- Reset mid-transaction abandons the transaction silently; the controller is reset by the same nreset.

Master handshake rules:
- A master raises m_req[i] and holds address, data and nwr stable until it sees m_ack[i]=1.
- It then drops m_req[i]; m_ack[i] falls afterwards.
- A port is eligible when m_req[i]=1 and m_ack[i]=0.

State IDLE:
- Entered only with s_ack=0.
- If any port is eligible, pick a winner:
  - if P0_PRIORITY=1 and port 0 is eligible, port 0 wins;
  - otherwise search cyclically from last+1.
- On a win: latch the winner's address/data/nwr into s_address/s_data_out/s_nwr, set grant, s_req<=1, go to REQ.
- Latency: m_req sampled high at edge N gives s_req high after edge N.

State REQ:
- Count cycles.
- When s_ack=1: m_rdata<=s_data_in, m_ack[grant]<=1, s_req<=0, go to RELEASE.
- When the count reaches TIMEOUT_CYCLES: err_timeout<=1, but stay in REQ (the transaction is not aborted).
- The counter clears on entry to REQ.

State RELEASE:
- Wait until s_ack=0 and m_req[grant]=0. These two conditions may be met in either order or in the same cycle.
- Then m_ack[grant]<=0, last<=grant, go to IDLE.
- Minimum gap between s_req pulses is therefore 2 cycles.

Other rules:
- A request arriving on a port while another port is served stays pending; it is never lost.
- Simultaneous requests on all ports are served in priority/round-robin order.
- m_rdata stays unchanged after writes.
- err_timeout is cleared only by reset.

Test Plan:
- Single read on port 1 (address 0x000123, nwr 4'hF), controller model acks after 6 cycles with 0xDEADBEEF -> s_req rises 1 cycle after m_req; s_address=0x000123; m_rdata=0xDEADBEEF while m_ack[1]=1; grant=1.
- Ports 1 and 2 request continuously, P0_PRIORITY=0 -> grants alternate 1,2,1,2; no port is served twice in a row.
- Ports 0, 1 and 2 request together, P0_PRIORITY=1, port 0 re-requests immediately after each release -> port 0 is served every time, and port 1/2 are served only in cycles where port 0 is not eligible.
- Write on port 2 (data 0x11223344, nwr 4'b1100) while port 1 raises m_req mid-transaction -> s_data_out=0x11223344, s_nwr=4'b1100; port 1 is served next; m_rdata keeps its previous value after the write.
- Controller never acks, TIMEOUT_CYCLES=8 -> err_timeout rises after 8 cycles in REQ; s_req stays high; a later ack completes normally; err_timeout stays 1.
- nreset asserted while in REQ and while in RELEASE -> next cycle: all outputs at reset values; the next request goes to port 0 first if it is pending.
